out_port_arbiter: RTL
=====================

OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters (input ports competing for this output); legal range 2..4.
REQ-002 Parameter PKT_W, default 16: packet width; bits [PKT_W-1:PKT_W-4] hold signed 4-bit dx.
REQ-003 Parameter CREDITS, default 4: downstream buffer depth in packets; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 req_valid  in  N_REQ  per-requester packet-present flag.
REQ-007 req_packet  in  N_REQ*PKT_W  requester i packet at bits [i*PKT_W +: PKT_W].
REQ-008 req_ready  out  N_REQ  one-hot grant; combinational; requester i's packet is consumed in any cycle where req_valid[i] and req_ready[i] are both 1.
REQ-009 out_packet  out  PKT_W  registered forwarded packet.
REQ-010 out_valid  out  1  registered one-cycle strobe per forwarded packet.
REQ-011 credit_return  in  1  one-cycle pulse; downstream freed one buffer slot.
REQ-012 credit_cnt  out  4  current credit count.
REQ-013 err_overflow  out  1  sticky; credit returned while already at CREDITS.

Function
REQ-014 Grant is allowed in a cycle iff credit_cnt != 0 and at least one req_valid bit is set; otherwise req_ready = 0.
REQ-015 Round-robin: search starts at rr_ptr and wraps modulo N_REQ; the first requester with req_valid set is granted.
REQ-016 After a grant to requester g, rr_ptr <= (g+1) mod N_REQ; with no grant, rr_ptr holds.
REQ-017 req_ready shall never assert for a requester whose req_valid is 0; at most one bit is set.
REQ-018 On a grant, out_packet <= granted packet unmodified and out_valid <= 1 on the next edge (latency 1 cycle); otherwise out_valid <= 0 and out_packet holds.
REQ-019 credit_cnt update: grant only -> -1; credit_return only -> +1; both in the same cycle -> unchanged; neither -> unchanged.
REQ-020 The grant decision uses the registered credit_cnt; a same-cycle credit_return does not enable a grant at credit_cnt = 0.
REQ-021 credit_return at credit_cnt = CREDITS with no same-cycle grant -> count unchanged, err_overflow <= 1; err_overflow clears only on reset.
REQ-022 Sustained throughput: one packet per cycle while credits are available; back-to-back grants to different requesters are allowed.
REQ-023 With a single persistent requester, it is granted every cycle that credits allow; no idle insertion.

Reset
REQ-024 While rst_n = 0: out_valid = 0, out_packet = 0, credit_cnt = CREDITS, rr_ptr = 0, err_overflow = 0, req_ready = 0.
REQ-025 Reset asserted mid-stream: an in-flight out_valid is dropped immediately; no packet is granted in the first cycle after rst_n rises only if credit_cnt is 0 (otherwise normal arbitration resumes in that cycle).

Configuration
REQ-026 Macro OUT_PORT_ARBITER_STATS_EN defined: adds input stat_clr (1 bit) and output stat_grants (N_REQ*8); per-requester 8-bit grant counters, saturating at 255, cleared by reset or stat_clr (stat_clr wins over a same-cycle grant).
REQ-027 Macro not defined: stat_clr and stat_grants ports and counters are absent; all other behaviour is identical.

Verification
REQ-028 Reset, then req_valid = 3'b111 held with packets 0x3000/0xE000/0x0000 and credit_return pulsed every cycle -> grants in the order 0,1,2,0,1,2; out_valid is continuous and out_packet follows one cycle behind each grant.
REQ-029 CREDITS = 4, no credit_return, req_valid = 3'b001 -> exactly 4 out_valid strobes, then credit_cnt = 0 and req_ready = 0; a single credit_return pulse -> exactly one further grant.
REQ-030 credit_cnt = 0 with credit_return and req_valid both asserted in the same cycle -> no grant in that cycle, credit_cnt = 1 next cycle, grant in the following cycle.
REQ-031 Reset state (credit_cnt = 4), credit_return pulsed with no requests -> err_overflow = 1 and stays 1; credit_cnt remains 4.
REQ-032 Reset asserted in the cycle after a grant -> out_valid = 0 and credit_cnt = 4 immediately; rr_ptr = 0 after release.
REQ-033 With STATS_EN: 300 grants to requester 1 -> stat_grants[15:8] = 255; stat_clr -> 0 next cycle.

Source files
------------

// File: rtl/out_port_arbiter.sv
// Round-robin output-port arbiter with credit-based flow control toward a downstream buffer.
// Optional per-requester grant statistics are built in when OUT_PORT_ARBITER_STATS_EN is defined.
module out_port_arbiter #(
  parameter int N_REQ   = 3,
  parameter int PKT_W   = 16,
  parameter int CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*PKT_W-1:0] req_packet,
  output logic [N_REQ-1:0]       req_ready,
  output logic [PKT_W-1:0]       out_packet,
  output logic                   out_valid,
  input  logic                   credit_return,
  output logic [3:0]             credit_cnt,
  output logic                   err_overflow
`ifdef OUT_PORT_ARBITER_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [N_REQ*8-1:0]     stat_grants
`endif
);

  // Handshake: requester i's packet is taken in any cycle where req_valid[i] and
  // req_ready[i] are both 1; req_ready is one-hot, combinational, and never depends
  // on a same-cycle credit_return (only the registered credit_cnt gates it).

  localparam int              PTR_W      = 2;
  localparam logic [3:0]      CREDIT_MAX = 4'(CREDITS);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;
  logic [N_REQ-1:0] grant_vec;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    if (rst_n && (credit_cnt != 4'd0)) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % N_REQ;
        if (!grant_any && req_valid[idx]) begin
          grant_any      = 1'b1;
          grant_idx      = PTR_W'(idx);
          grant_vec[idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
    end else begin
      out_valid <= grant_any;
      if (grant_any) begin
        out_packet <= req_packet[grant_idx*PKT_W +: PKT_W];
      end
    end
  end

  // A grant and a returned credit in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt   <= CREDIT_MAX;
      err_overflow <= 1'b0;
    end else begin
      if (grant_any && !credit_return) begin
        credit_cnt <= credit_cnt - 4'd1;
      end else if (credit_return && !grant_any) begin
        if (credit_cnt == CREDIT_MAX) begin
          err_overflow <= 1'b1;
        end else begin
          credit_cnt <= credit_cnt + 4'd1;
        end
      end
    end
  end

`ifdef OUT_PORT_ARBITER_STATS_EN
  logic [7:0] grant_cnt [N_REQ];

  // Saturating counters; stat_clr takes priority over a same-cycle grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= 8'd0;
    end else if (stat_clr) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_vec[i] && (grant_cnt[i] != 8'hFF)) grant_cnt[i] <= grant_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_REQ; i++) stat_grants[i*8 +: 8] = grant_cnt[i];
  end
`endif

endmodule
